// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection of one execution-unit result per
// cycle, broadcast on a registered bus, plus a saturating contention counter.

package fcpu_pkg;
    localparam int RSV_ID_W = 6;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;
endpackage

module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       clear,
    input  logic [N_UNITS*CDB_W-1:0]   i_cdb,
    input  logic [N_UNITS-1:0]         i_valid,
    output logic [N_UNITS-1:0]         i_ready,
    output logic [CDB_W-1:0]           cdb,
    output logic                       cdb_valid,
    output logic [CNT_W-1:0]           o_conflicts
);

    localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] grant_idx, scan_idx;
    logic [PTR_W:0]   scan_sum;
    logic             found;
    logic             xfer;
    logic [CDB_W-1:0] sel_data;
    logic [CDB_W-1:0] cdb_q, cdb_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [CNT_W-1:0] conflicts_q, conflicts_d;

    // Scan from rr_ptr upward with an explicit wrap so non-power-of-2 counts work.
    always_comb begin
        grant_idx = '0;
        scan_idx  = '0;
        scan_sum  = '0;
        found     = 1'b0;
        for (int off = 0; off < N_UNITS; off++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
            if (scan_sum >= (PTR_W+1)'(N_UNITS)) begin
                scan_sum = scan_sum - (PTR_W+1)'(N_UNITS);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!found && i_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        i_ready = '0;
        if (found && nrst && !clear) begin
            i_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (i_ready[k]) begin
                sel_data = sel_data | i_cdb[k*CDB_W +: CDB_W];
            end
        end
    end

    assign xfer = |i_ready;

    always_comb begin
        cdb_d       = cdb_q;
        cdb_valid_d = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        conflicts_d = conflicts_q;
        if (xfer) begin
            cdb_d       = sel_data;
            cdb_valid_d = 1'b1;
            rr_ptr_d    = (grant_idx == PTR_W'(N_UNITS-1)) ? '0 : grant_idx + PTR_W'(1);
        end
        if (clear) begin
            rr_ptr_d = '0;
        end
        // Contention is sampled on the raw offers, not on what was granted.
        if (!clear && ($countones(i_valid) >= 2) && (conflicts_q != '1)) begin
            conflicts_d = conflicts_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            conflicts_q <= '0;
        end else begin
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign cdb         = cdb_q;
    assign cdb_valid   = cdb_valid_q;
    assign o_conflicts = conflicts_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random offers, all checked against
// a queue-free round-robin reference model computed with modulo arithmetic.

module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int N  = 4;
    localparam int CW = 4;

    logic               clk;
    logic               nrst;
    logic               clear;
    logic [N*CDB_W-1:0] i_cdb;
    logic [N-1:0]       i_valid;
    logic [N-1:0]       i_ready;
    logic [CDB_W-1:0]   cdb;
    logic               cdb_valid;
    logic [CW-1:0]      o_conflicts;

    cdb_arbiter #(.N_UNITS(N), .CNT_W(CW)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .clear       (clear),
        .i_cdb       (i_cdb),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .cdb         (cdb),
        .cdb_valid   (cdb_valid),
        .o_conflicts (o_conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Pending offers per unit; a unit keeps its offer until it is accepted.
    logic             off_valid [N];
    logic [CDB_W-1:0] off_data  [N];

    // Reference model state.
    int               m_rr;
    int               m_cnt;
    logic [CDB_W-1:0] m_cdb;
    logic             m_valid;
    int               last_grant;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (!nrst || clear) return -1;
        for (int off = 0; off < N; off++) begin
            if (off_valid[(m_rr + off) % N]) return (m_rr + off) % N;
        end
        return -1;
    endfunction

    task automatic cycle();
        int g;
        int nv;
        logic [N-1:0] exp_ready;
        for (int k = 0; k < N; k++) begin
            i_valid[k]                = off_valid[k];
            i_cdb[k*CDB_W +: CDB_W]   = off_data[k];
        end
        @(negedge clk);
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("i_ready", 64'(i_ready), 64'(exp_ready));
        nv = 0;
        for (int k = 0; k < N; k++) nv += int'(off_valid[k]);
        if (!nrst) begin
            m_rr = 0; m_cnt = 0; m_cdb = '0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (g >= 0) begin
                m_cdb   = off_data[g];
                m_valid = 1'b1;
                m_rr    = (g + 1) % N;
            end
            if (clear) m_rr = 0;
            if (!clear && nv >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(posedge clk);
        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        if (m_valid || !nrst) check("cdb", 64'(cdb), 64'(m_cdb));
        check("o_conflicts", 64'(o_conflicts), 64'(m_cnt));
        if (g >= 0) off_valid[g] = 1'b0;
        last_grant = g;
    endtask

    task automatic offer(input int k, input logic [RSV_ID_W-1:0] id, input logic [DATA_W-1:0] d);
        off_valid[k] = 1'b1;
        off_data[k]  = {id, d};
    endtask

    task automatic drop_all();
        for (int k = 0; k < N; k++) off_valid[k] = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        cycle();
        nrst = 1'b1;
    endtask

    initial begin
        nrst = 1'b0; clear = 1'b0; i_valid = '0; i_cdb = '0;
        m_rr = 0; m_cnt = 0; m_cdb = '0; m_valid = 1'b0; last_grant = -1;
        for (int k = 0; k < N; k++) begin
            off_valid[k] = 1'b0;
            off_data[k]  = '0;
        end
        @(posedge clk); #1;

        // Reset with every unit offering.
        for (int k = 0; k < N; k++) offer(k, RSV_ID_W'(k + 1), DATA_W'(32'hA000 + k));
        cycle();
        cycle();
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_conflicts", 64'(o_conflicts), 64'(0));
        nrst = 1'b1;
        drop_all();

        // Single unit.
        offer(2, 6'd5, 32'h0000_0042);
        cycle();
        check("single_grant", 64'(last_grant), 64'(2));
        check("single_cdb", 64'(cdb), 64'({6'd5, 32'h0000_0042}));
        cycle();
        check("single_pulse_end", 64'(cdb_valid), 64'(0));

        // Round robin from pointer 0.
        do_reset();
        for (int k = 0; k < N; k++) offer(k, RSV_ID_W'(10 + k), DATA_W'(32'hB000 + k));
        for (int k = 0; k < N; k++) begin
            cycle();
            check("rr_order", 64'(last_grant), 64'(k));
            check("rr_pulse", 64'(cdb_valid), 64'(1));
        end
        check("rr_conflicts", 64'(o_conflicts), 64'(3));

        // Wrap: move pointer to 3, then units 0 and 3 compete.
        offer(2, 6'd1, 32'h1);
        cycle();
        offer(0, 6'd20, 32'hC000);
        offer(3, 6'd23, 32'hC003);
        cycle();
        check("wrap_first", 64'(last_grant), 64'(3));
        cycle();
        check("wrap_second", 64'(last_grant), 64'(0));
        offer(0, 6'd2, 32'h2);
        offer(1, 6'd3, 32'h3);
        cycle();
        check("wrap_ptr_is_1", 64'(last_grant), 64'(1));
        cycle();
        drop_all();

        // Flush blocks acceptance and resets the pointer.
        offer(1, 6'd7, 32'hD001);
        clear = 1'b1;
        cycle();
        check("flush_no_grant", 64'(last_grant), 64'(-1));
        clear = 1'b0;
        cycle();
        check("flush_then_grant", 64'(last_grant), 64'(1));
        cycle();

        // Saturation: two units always offering.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (!off_valid[0]) offer(0, RSV_ID_W'(c), DATA_W'(32'hE000 + c));
            if (!off_valid[1]) offer(1, RSV_ID_W'(c), DATA_W'(32'hF000 + c));
            cycle();
        end
        check("sat_conflicts", 64'(o_conflicts), 64'(15));
        drop_all();

        // Random offers, flushes and resets.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!off_valid[k] && ($urandom_range(0, 1) == 1)) begin
                    offer(k, RSV_ID_W'($urandom), DATA_W'($urandom));
                end
            end
            clear = ($urandom_range(0, 15) == 0);
            nrst  = ($urandom_range(0, 39) != 0);
            cycle();
            if (!nrst || clear) begin
                for (int k = 0; k < N; k++) begin
                    if ($urandom_range(0, 1) == 1) off_valid[k] = 1'b0;
                end
            end
        end
        clear = 1'b0;
        nrst  = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
